// File: rtl/spi_master_pkg.sv
// Shared SPI master types: byte-packer FSM states and lane/width helpers sized from the word width.
package spi_master_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } packer_state_t;

   function automatic int packer_lanes(input int data_width);
      return data_width / 8;
   endfunction

   // Wide enough to hold the lane count itself, not just a lane index.
   function automatic int packer_bytes_w(input int data_width);
      return $clog2(data_width / 8) + 1;
   endfunction

endpackage

// File: rtl/spi_byte_packer.sv
// Packs a byte stream into DATA_WIDTH words; valid_o follows the completing byte by 1 cycle, ready_o drops while a word stalls.
// Lane order: SPI_PACKER_MSB_FIRST_EN defined puts lane 0 at the top byte, otherwise at data_o[7:0].
module spi_byte_packer
   import spi_master_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                  s_axi_aclk,
   input  logic                                  s_axi_aresetn,
   input  logic                                  clr_i,
   input  logic                                  valid_i,
   input  logic [7:0]                            data_i,
   input  logic                                  last_i,
   output logic                                  ready_o,
   output logic                                  valid_o,
   output logic [DATA_WIDTH-1:0]                 data_o,
   output logic                                  last_o,
   output logic [packer_bytes_w(DATA_WIDTH)-1:0] bytes_o,
   input  logic                                  ready_i,
   output logic [CNT_WIDTH-1:0]                  words_o
);

   localparam int LANES = packer_lanes(DATA_WIDTH);
   localparam int BW    = packer_bytes_w(DATA_WIDTH);
   localparam int LW    = BW - 1;

   packer_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0]  acc_q, acc_merged;
   logic [LW-1:0]          cnt_q;
   logic [LW+2:0]          lane_pos;
   logic                   byte_xfer, word_xfer, word_done;

`ifdef SPI_PACKER_MSB_FIRST_EN
   assign lane_pos = (LW+3)'(DATA_WIDTH - 8) - {cnt_q, 3'b000};
`else
   assign lane_pos = {cnt_q, 3'b000};
`endif

   assign valid_o = (state_q == HOLD);

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ready_o    = !clr_i && ((state_q == FILL) || ready_i);
      byte_xfer  = valid_i && ready_o;
      word_xfer  = valid_o && ready_i;
      word_done  = byte_xfer && (last_i || (cnt_q == LW'(LANES - 1)));
      acc_merged = acc_q;
      acc_merged[lane_pos +: 8] = data_i;

      case (state_q)
         FILL: if (word_done) state_d = HOLD;
         // A completing byte can only land here alongside a word transfer, so staying put reloads.
         HOLD: if (word_xfer && !word_done) state_d = FILL;
         default: state_d = FILL;
      endcase

      if (clr_i) state_d = FILL;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         data_o  <= '0;
         bytes_o <= '0;
         last_o  <= 1'b0;
         words_o <= '0;
      end else if (clr_i) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         data_o  <= '0;
         bytes_o <= '0;
         last_o  <= 1'b0;
         words_o <= '0;
      end else begin
         if (byte_xfer) begin
            if (word_done) begin
               acc_q   <= '0;
               cnt_q   <= '0;
               data_o  <= acc_merged;
               bytes_o <= BW'(cnt_q) + BW'(1);
               last_o  <= last_i;
            end else begin
               acc_q <= acc_merged;
               cnt_q <= cnt_q + LW'(1);
            end
         end
         if (word_xfer) begin
            words_o <= words_o + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_spi_byte_packer.sv
// Self-checking bench for spi_byte_packer: directed scenarios plus a randomized stream against a byte-grouping model.
`timescale 1ns/1ps
module tb_spi_byte_packer;

   localparam int DW    = 32;
   localparam int CW    = 16;
   localparam int LANES = DW / 8;
   localparam int BW    = $clog2(LANES) + 1;

   logic          s_axi_aclk = 1'b0;
   logic          s_axi_aresetn, clr_i, valid_i, last_i, ready_i;
   logic [7:0]    data_i;
   logic          ready_o, valid_o, last_o;
   logic [DW-1:0] data_o;
   logic [BW-1:0] bytes_o;
   logic [CW-1:0] words_o;

   typedef struct {
      logic [DW-1:0] d;
      logic [BW-1:0] n;
      logic          l;
   } word_t;

   word_t      exp_q[$];
   logic [7:0] acc_q[$];
   int         total = 0;
   int         bad   = 0;

   always #5 s_axi_aclk = ~s_axi_aclk;

   spi_byte_packer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .clr_i         (clr_i),
      .valid_i       (valid_i),
      .data_i        (data_i),
      .last_i        (last_i),
      .ready_o       (ready_o),
      .valid_o       (valid_o),
      .data_o        (data_o),
      .last_o        (last_o),
      .bytes_o       (bytes_o),
      .ready_i       (ready_i),
      .words_o       (words_o)
   );

   // Byte b as the k-th byte of a word, placed by the configured lane order.
   function automatic logic [DW-1:0] lane_word(input logic [7:0] b, input int k);
`ifdef SPI_PACKER_MSB_FIRST_EN
      return DW'(b) << (DW - 8 - 8 * k);
`else
      return DW'(b) << (8 * k);
`endif
   endfunction

   function automatic void model_push(input logic [7:0] b, input logic l);
      word_t w;
      acc_q.push_back(b);
      if (l || acc_q.size() == LANES) begin
         w.d = '0;
         foreach (acc_q[k]) w.d = w.d | lane_word(acc_q[k], k);
         w.n = BW'(acc_q.size());
         w.l = l;
         exp_q.push_back(w);
         acc_q.delete();
      end
   endfunction

   task automatic tick();
      @(posedge s_axi_aclk);
      #1;
   endtask

   task automatic do_clear();
      clr_i   = 1'b1;
      valid_i = 1'b0;
      last_i  = 1'b0;
      tick();
      clr_i = 1'b0;
      exp_q.delete();
      acc_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic l);
      valid_i = 1'b1;
      data_i  = b;
      last_i  = l;
      tick();
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   task automatic test_reset();
      ready_i = 1'b0;
      repeat (2) tick();
      total++;
      if ({valid_o, last_o, data_o, bytes_o, words_o, ready_o} !== {1'b0, 1'b0, DW'(0), BW'(0), CW'(0), 1'b1})
         begin bad++; $display("FAIL reset_state: got v=%b l=%b d=%h n=%0d w=%0d r=%b, want 0 0 0 0 0 1", valid_o, last_o, data_o, bytes_o, words_o, ready_o); end
      s_axi_aresetn = 1'b1;
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) send_byte(8'(8'h30 + i), 1'b0);
      tick();
      send_byte(8'h5A, 1'b0);
      send_byte(8'h6B, 1'b0);
      ready_i = 1'b0;
      #3 s_axi_aresetn = 1'b0;
      #1;
      total++;
      if ({valid_o, last_o, data_o, bytes_o, words_o} !== {1'b0, 1'b0, DW'(0), BW'(0), CW'(0)})
         begin bad++; $display("FAIL reset_async: got v=%b l=%b d=%h n=%0d w=%0d, want all zero", valid_o, last_o, data_o, bytes_o, words_o); end
      tick();
      s_axi_aresetn = 1'b1;
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_no_word: got valid_o=%b want 0", valid_o); end
      end
      send_byte(8'h77, 1'b1);
      total++;
      if ({valid_o, data_o, bytes_o, last_o} !== {1'b1, lane_word(8'h77, 0), BW'(1), 1'b1})
         begin bad++; $display("FAIL reset_partial_dropped: got v=%b d=%h n=%0d l=%b, want 1 %h 1 1", valid_o, data_o, bytes_o, last_o, lane_word(8'h77, 0)); end
      tick();
   endtask

   task automatic test_word();
      logic [7:0]    b4[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [DW-1:0] want;
`ifdef SPI_PACKER_MSB_FIRST_EN
      want = 32'h11223344;
`else
      want = 32'h44332211;
`endif
      do_clear();
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         valid_i = 1'b1;
         data_i  = b4[i];
         last_i  = 1'b0;
         #1;
         total++;
         if (ready_o !== 1'b1) begin bad++; $display("FAIL word_ready: byte %0d got ready_o=%b want 1", i, ready_o); end
         tick();
         if (i < 3) begin
            total++;
            if (valid_o !== 1'b0) begin bad++; $display("FAIL word_early: after byte %0d got valid_o=%b want 0", i, valid_o); end
         end
      end
      valid_i = 1'b0;
      total++;
      if ({valid_o, data_o, bytes_o, last_o} !== {1'b1, want, BW'(4), 1'b0})
         begin bad++; $display("FAIL word_full: got v=%b d=%h n=%0d l=%b, want 1 %h 4 0", valid_o, data_o, bytes_o, last_o, want); end
      tick();
      total++;
      if ({valid_o, words_o} !== {1'b0, CW'(1)})
         begin bad++; $display("FAIL word_count: got v=%b words=%0d, want 0 1", valid_o, words_o); end
   endtask

   task automatic test_partial_last();
      logic [DW-1:0] want3, want1;
`ifdef SPI_PACKER_MSB_FIRST_EN
      want3 = 32'hAABBCC00;
      want1 = 32'h5E000000;
`else
      want3 = 32'h00CCBBAA;
      want1 = 32'h0000005E;
`endif
      do_clear();
      ready_i = 1'b0;
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b1);
      total++;
      if ({valid_o, data_o, bytes_o, last_o} !== {1'b1, want3, BW'(3), 1'b1})
         begin bad++; $display("FAIL partial_word: got v=%b d=%h n=%0d l=%b, want 1 %h 3 1", valid_o, data_o, bytes_o, last_o, want3); end
      repeat (2) tick();
      total++;
      if ({valid_o, data_o, bytes_o, last_o, ready_o} !== {1'b1, want3, BW'(3), 1'b1, 1'b0})
         begin bad++; $display("FAIL partial_hold: got v=%b d=%h n=%0d l=%b r=%b, want 1 %h 3 1 0", valid_o, data_o, bytes_o, last_o, ready_o, want3); end
      ready_i = 1'b1;
      tick();
      total++;
      if ({valid_o, words_o} !== {1'b0, CW'(1)})
         begin bad++; $display("FAIL partial_count: got v=%b words=%0d, want 0 1", valid_o, words_o); end
      send_byte(8'h5E, 1'b1);
      total++;
      if ({valid_o, data_o, bytes_o, last_o} !== {1'b1, want1, BW'(1), 1'b1})
         begin bad++; $display("FAIL single_last: got v=%b d=%h n=%0d l=%b, want 1 %h 1 1", valid_o, data_o, bytes_o, last_o, want1); end
      tick();
   endtask

   task automatic test_back_to_back();
      int        idx = 0, stalls = 0;
      logic      was_stall = 1'b0;
      logic [DW+BW:0] held = '0;
      word_t     w;
      do_clear();
      for (int c = 0; c < 60 && !(idx == 12 && exp_q.size() == 0); c++) begin
         ready_i = (c < 5) || (c >= 11);
         valid_i = (idx < 12);
         data_i  = 8'(8'h10 + idx);
         last_i  = 1'b0;
         @(negedge s_axi_aclk);
         if (was_stall) begin
            total++;
            if (!valid_o || {data_o, bytes_o, last_o} !== held)
               begin bad++; $display("FAIL b2b_stable: got v=%b d=%h, want held %h", valid_o, data_o, held); end
         end
         if (valid_o && !ready_i) begin
            total++;
            stalls++;
            if (ready_o !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready: got ready_o=%b want 0", ready_o); end
         end
         was_stall = valid_o && !ready_i;
         held = {data_o, bytes_o, last_o};
         if (valid_o && ready_i) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_word: unexpected word data=%h", data_o); end
            else begin
               w = exp_q.pop_front();
               if (data_o !== w.d || bytes_o !== w.n || last_o !== w.l)
                  begin bad++; $display("FAIL b2b_word: got d=%h n=%0d l=%b, want d=%h n=%0d l=%b", data_o, bytes_o, last_o, w.d, w.n, w.l); end
            end
         end
         if (valid_i && ready_o) begin
            model_push(data_i, last_i);
            idx++;
         end
         tick();
      end
      valid_i = 1'b0;
      total++;
      if (idx != 12 || exp_q.size() != 0 || stalls != 3 || words_o !== CW'(3))
         begin bad++; $display("FAIL b2b_done: got sent=%0d pending=%0d stalls=%0d words=%0d, want 12 0 3 3", idx, exp_q.size(), stalls, words_o); end
   endtask

   task automatic test_clear();
      logic [DW-1:0] want;
`ifdef SPI_PACKER_MSB_FIRST_EN
      want = 32'h01020304;
`else
      want = 32'h04030201;
`endif
      do_clear();
      ready_i = 1'b1;
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      clr_i   = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'hEE;
      #1;
      total++;
      if (ready_o !== 1'b0) begin bad++; $display("FAIL clear_ready: got ready_o=%b want 0", ready_o); end
      tick();
      clr_i = 1'b0;
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
      total++;
      if ({valid_o, data_o, bytes_o, last_o} !== {1'b1, want, BW'(4), 1'b0})
         begin bad++; $display("FAIL clear_word: got v=%b d=%h n=%0d l=%b, want 1 %h 4 0", valid_o, data_o, bytes_o, last_o, want); end
      repeat (3) tick();
      total++;
      if ({valid_o, words_o} !== {1'b0, CW'(1)})
         begin bad++; $display("FAIL clear_count: got v=%b words=%0d, want 0 1", valid_o, words_o); end
      ready_i = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'hC0, 1'b0);
      ready_i = 1'b1;
      clr_i   = 1'b1;
      tick();
      clr_i = 1'b0;
      total++;
      if ({valid_o, words_o, data_o} !== {1'b0, CW'(0), DW'(0)})
         begin bad++; $display("FAIL clear_pending: got v=%b words=%0d d=%h, want 0 0 0", valid_o, words_o, data_o); end
   endtask

   task automatic test_random();
      int    sent = 0, seen = 0;
      int    n = 300;
      logic  was_stall = 1'b0, took;
      logic [DW+BW:0] held = '0;
      word_t w;
      do_clear();
      for (int c = 0; c < 4000 && !(sent == n && exp_q.size() == 0); c++) begin
         if (!valid_i && sent < n && $urandom_range(3) != 0) begin
            valid_i = 1'b1;
            data_i  = 8'($urandom);
            last_i  = ($urandom_range(4) == 0) || (sent == n - 1);
         end
         ready_i = ($urandom_range(2) != 0);
         @(negedge s_axi_aclk);
         if (was_stall) begin
            total++;
            if (!valid_o || {data_o, bytes_o, last_o} !== held)
               begin bad++; $display("FAIL rnd_stable: got v=%b d=%h, want held %h", valid_o, data_o, held); end
         end
         was_stall = valid_o && !ready_i;
         held = {data_o, bytes_o, last_o};
         if (valid_o && ready_i) begin
            total++;
            seen++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_word: unexpected word data=%h", data_o); end
            else begin
               w = exp_q.pop_front();
               if (data_o !== w.d || bytes_o !== w.n || last_o !== w.l)
                  begin bad++; $display("FAIL rnd_word: got d=%h n=%0d l=%b, want d=%h n=%0d l=%b", data_o, bytes_o, last_o, w.d, w.n, w.l); end
            end
         end
         took = valid_i && ready_o;
         if (took) begin
            model_push(data_i, last_i);
            sent++;
         end
         tick();
         if (took) begin
            valid_i = 1'b0;
            last_i  = 1'b0;
         end
      end
      total++;
      if (sent != n || exp_q.size() != 0 || words_o !== CW'(seen) || valid_o !== 1'b0)
         begin bad++; $display("FAIL rnd_done: got sent=%0d pending=%0d words=%0d v=%b, want %0d 0 %0d 0", sent, exp_q.size(), words_o, valid_o, n, seen); end
   endtask

   task automatic test_wrap();
      int xfers = 0, rdy_low = 0;
      do_clear();
      ready_i = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         valid_i = 1'b1;
         data_i  = 8'(i);
         last_i  = 1'b1;
         @(negedge s_axi_aclk);
         if (!ready_o) rdy_low++;
         if (valid_o && ready_i) xfers++;
         tick();
      end
      valid_i = 1'b0;
      last_i  = 1'b0;
      @(negedge s_axi_aclk);
      total++;
      if (words_o !== 16'hFFFF || xfers != 65535)
         begin bad++; $display("FAIL wrap_max: got words=%h xfers=%0d, want ffff 65535", words_o, xfers); end
      if (valid_o && ready_i) xfers++;
      tick();
      total++;
      if (words_o !== CW'(0) || xfers != 65536 || valid_o !== 1'b0)
         begin bad++; $display("FAIL wrap_zero: got words=%h xfers=%0d v=%b, want 0 65536 0", words_o, xfers, valid_o); end
      total++;
      if (rdy_low != 0) begin bad++; $display("FAIL wrap_rate: got %0d cycles with ready_o low, want 0", rdy_low); end
   endtask

   initial begin
      s_axi_aresetn = 1'b0;
      clr_i   = 1'b0;
      valid_i = 1'b0;
      data_i  = 8'h00;
      last_i  = 1'b0;
      ready_i = 1'b0;
      test_reset();
      test_word();
      test_partial_last();
      test_back_to_back();
      test_clear();
      test_random();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_byte_packer.md
SPI_BYTE_PACKER -- requirements
Module: spi_byte_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output word width; multiple of 8, min 16.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of emitted-word counter.
REQ-003 SHALL have port s_axi_aclk  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port s_axi_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr_i  input  1  synchronous clear, driven by spi_swrst.
REQ-006 SHALL have port valid_i  input  1  byte-stream valid.
REQ-007 SHALL have port data_i  input  8  byte-stream data.
REQ-008 SHALL have port last_i  input  1  final byte of a transfer.
REQ-009 SHALL have port ready_o  output  1  byte-stream ready.
REQ-010 SHALL have port valid_o  output  1  word valid, drives TX FIFO valid_i.
REQ-011 SHALL have port data_o  output  DATA_WIDTH  packed word, drives TX FIFO data_i.
REQ-012 SHALL have port last_o  output  1  word closes a transfer.
REQ-013 SHALL have port bytes_o  output  clog2(DATA_WIDTH/8)+1  valid bytes in data_o (1..DATA_WIDTH/8).
REQ-014 SHALL have port ready_i  input  1  word ready, from TX FIFO ready_o.
REQ-015 SHALL have port words_o  output  CNT_WIDTH  words emitted since reset/clear.

Function
REQ-016 SHALL transfer a byte when valid_i && ready_o, a word when valid_o && ready_i.
REQ-017 SHALL drive ready_o = !clr_i && (!valid_o || ready_i), combinationally.
REQ-018 SHALL hold valid_o, data_o, last_o, bytes_o stable while valid_o && !ready_i.
REQ-019 SHALL keep two states: FILL (accumulating, output register empty or draining) and HOLD (output register full, stalled); HOLD exits to FILL on word transfer.
REQ-020 SHALL place accepted bytes into an accumulator at lane index byte_cnt, then increment byte_cnt.
REQ-021 SHALL complete a word when the accepted byte fills lane DATA_WIDTH/8-1 or carries last_i.
REQ-022 SHALL, on completion, load the output register and assert valid_o on the following cycle (1-cycle latency), reset byte_cnt and the accumulator to 0.
REQ-023 SHALL zero-fill unused lanes of a partial word; bytes_o equals lanes written.
REQ-024 SHALL set last_o only on a word completed by a last_i byte.
REQ-025 SHALL sustain one byte per cycle when ready_i is held high.
REQ-026 SHALL allow a word transfer and a completing byte in the same cycle; the new word replaces the old with valid_o remaining high.
REQ-027 SHALL increment words_o on each word transfer, wrapping from all-ones to 0.
REQ-028 SHALL, when clr_i is high, discard the accumulator, byte_cnt, output register and words_o next cycle; a simultaneous byte or word handshake is ignored/lost.
REQ-029 SHALL emit nothing for last_i on an empty accumulator other than a 1-byte word containing that byte.

Reset
REQ-030 SHALL, with s_axi_aresetn low, asynchronously force valid_o=0, last_o=0, data_o=0, bytes_o=0, words_o=0, byte_cnt=0, state FILL; ready_o then reads 1.
REQ-031 SHALL discard any partial word on reset mid-transfer; no word emitted after release until new bytes arrive.

Configuration
REQ-032 SHALL honour macro SPI_PACKER_MSB_FIRST_EN: defined, lane 0 maps to data_o[DATA_WIDTH-1 -: 8] and lanes proceed downward (zero-fill at bottom); undefined, lane 0 maps to data_o[7:0] and proceeds upward (zero-fill at top).

Structure
REQ-033 SHALL take the state enum (FILL, HOLD) and lane-count/bytes_o width constants from shared package spi_master_pkg.
REQ-034 SHALL be a single module; no sub-modules.

Verification
REQ-035 SHALL test: bytes 11,22,33,44, ready_i=1, macro undefined -> one word 0x44332211, bytes_o=4, last_o=0, at cycle after 4th byte.
REQ-036 SHALL test: same bytes, macro defined -> 0x11223344.
REQ-037 SHALL test: bytes AA,BB,CC with last_i on CC, macro undefined -> 0x00CCBBAA, bytes_o=3, last_o=1, words_o=1.
REQ-038 SHALL test: 8 bytes back-to-back, ready_i=0 after first word -> ready_o=0 on 8th byte until ready_i=1; 2nd word intact, no byte lost or duplicated.
REQ-039 SHALL test: clr_i pulsed after 2 bytes, then 01,02,03,04 -> only 0x04030201 emitted, words_o=1.
REQ-040 SHALL test: words_o preset near wrap by 65536 transfers (CNT_WIDTH=16) -> words_o reads 0 after the 65536th word.
